// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the CDB writeback arbiter: buffered result entry,
// source indices and ROB-age arithmetic relative to the ROB head.
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W   = 5;
  localparam int CDB_PREG_W  = 7;
  localparam int CDB_DATA_W  = 32;
  localparam int NUM_CDB_SRC = 3;

  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_BR  = 2'd1;
  localparam logic [1:0] CDB_SRC_MEM = 2'd2;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  rob_tag;
    logic [CDB_PREG_W-1:0] pd;
    logic                  we;
    logic [CDB_DATA_W-1:0] data;
    logic                  live;
  } cdb_entry_t;

  // Distance from the ROB head; smaller means older.
  function automatic logic [CDB_TAG_W-1:0] cdb_age(input logic [CDB_TAG_W-1:0] tag,
                                                   input logic [CDB_TAG_W-1:0] head);
    return tag - head;
  endfunction

  function automatic logic cdb_younger(input logic [CDB_TAG_W-1:0] tag,
                                       input logic [CDB_TAG_W-1:0] flush_tag,
                                       input logic [CDB_TAG_W-1:0] head);
    return cdb_age(tag, head) > cdb_age(flush_tag, head);
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: circular FIFO with MSB-extended pointers, live-bit
// squash on flush, and self-removal of squashed (dead) heads.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  cdb_entry_t            push_entry,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [CDB_TAG_W-1:0]  flush_tag,
  input  logic [CDB_TAG_W-1:0]  rob_head,
  output logic [$clog2(DEPTH):0] count,
  output cdb_entry_t            head,
  output logic                  head_elig
);

  localparam int AW = $clog2(DEPTH);

  cdb_entry_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        head_dead;
  logic        do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign count     = wr_ptr - rd_ptr;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_dead = ~empty & ~head.live;
  // A head being squashed this cycle is already out of the running for the grant.
  assign head_elig = ~empty & head.live & ~(flush & cdb_younger(head.rob_tag, flush_tag, rob_head));
  assign do_pop    = head_dead | (pop & head_elig);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Payload storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_younger(mem[i].rob_tag, flush_tag, rob_head)) mem[i].live <= 1'b0;
      end
    end
    if (push) begin
      mem[wr_ptr[AW-1:0]]      <= push_entry;
      mem[wr_ptr[AW-1:0]].live <= ~(flush & cdb_younger(push_entry.rob_tag, flush_tag, rob_head));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter for ALU/branch/mem results. Define CDB_AGE_PRIO_EN for
// oldest-first grant; otherwise grants rotate round-robin from last_grant+1.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = CDB_TAG_W,
  parameter int PREG_W     = CDB_PREG_W,
  parameter int DATA_W     = CDB_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            src_valid,
  output logic [2:0]            src_ready,
  input  logic [3*TAG_W-1:0]    src_rob_tag,
  input  logic [3*PREG_W-1:0]   src_pd,
  input  logic [2:0]            src_we,
  input  logic [3*DATA_W-1:0]   src_data,
  input  logic                  flush,
  input  logic [TAG_W-1:0]      flush_tag,
  input  logic [TAG_W-1:0]      rob_head,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_rob_tag,
  output logic [PREG_W-1:0]     cdb_pd,
  output logic                  cdb_we,
  output logic [DATA_W-1:0]     cdb_data,
  output logic [1:0]            cdb_src
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cdb_entry_t             head [NUM_CDB_SRC];
  logic [CW-1:0]          cnt  [NUM_CDB_SRC];
  logic [NUM_CDB_SRC-1:0] elig;
  logic [NUM_CDB_SRC-1:0] pop;
  logic                   gnt_any;
  logic [1:0]             gnt_idx;
  cdb_entry_t             sel;

  // Handshake: a source transfers on any rising edge where src_valid[i] & src_ready[i];
  // src_ready depends only on registered occupancy and reset, never on src_valid.
  for (genvar g = 0; g < NUM_CDB_SRC; g++) begin : g_src
    cdb_entry_t entry;
    assign entry = '{rob_tag: src_rob_tag[g*TAG_W +: TAG_W],
                     pd:      src_pd[g*PREG_W +: PREG_W],
                     we:      src_we[g],
                     data:    src_data[g*DATA_W +: DATA_W],
                     live:    1'b1};
    assign src_ready[g] = reset & (cnt[g] < CW'(FIFO_DEPTH));
    assign pop[g]       = gnt_any & (gnt_idx == 2'(g));

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (src_valid[g] & src_ready[g]),
      .push_entry (entry),
      .pop        (pop[g]),
      .flush      (flush),
      .flush_tag  (flush_tag),
      .rob_head   (rob_head),
      .count      (cnt[g]),
      .head       (head[g]),
      .head_elig  (elig[g])
    );
  end

`ifdef CDB_AGE_PRIO_EN
  logic [TAG_W-1:0] best_age;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = CDB_SRC_ALU;
    sel      = head[0];
    best_age = '1;
    for (int i = 0; i < NUM_CDB_SRC; i++) begin
      if (elig[i] && (!gnt_any || cdb_age(head[i].rob_tag, rob_head) < best_age)) begin
        gnt_any  = 1'b1;
        gnt_idx  = 2'(i);
        sel      = head[i];
        best_age = cdb_age(head[i].rob_tag, rob_head);
      end
    end
  end
`else
  logic [1:0] last_grant;
  logic [1:0] idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = CDB_SRC_ALU;
    sel     = head[0];
    idx     = CDB_SRC_ALU;
    for (int k = 0; k < NUM_CDB_SRC; k++) begin
      idx = 2'((int'(last_grant) + 1 + k) % NUM_CDB_SRC);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
        sel     = head[idx];
      end
    end
  end

  // Reset value points at mem so the first search begins with the ALU.
  always_ff @(posedge clk) begin
    if (!reset)       last_grant <= CDB_SRC_MEM;
    else if (gnt_any) last_grant <= gnt_idx;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      cdb_valid   <= 1'b0;
      cdb_we      <= 1'b0;
      cdb_rob_tag <= '0;
      cdb_pd      <= '0;
      cdb_data    <= '0;
      cdb_src     <= CDB_SRC_ALU;
    end else if (gnt_any) begin
      cdb_valid   <= 1'b1;
      cdb_we      <= sel.we;
      cdb_rob_tag <= sel.rob_tag;
      cdb_pd      <= sel.pd;
      cdb_data    <= sel.data;
      cdb_src     <= gnt_idx;
    end else begin
      cdb_valid   <= 1'b0;
      cdb_we      <= 1'b0;
    end
  end

endmodule
